// File: rtl/alu_dispatch_unit.sv
// alu_dispatch_unit: circular dispatch queue feeding the ALU reservation
// station's dual-slot valid/ready insert port, two instructions per cycle
// in program order.
// Optional build macro ALU_DISPATCH_STATS_EN enables the dispatch/stall
// counters; without it both stat ports read zero and no counter flops exist.

package alu_dispatch_pkg;
   // Renamed ALU instruction as handed from rename to the reservation station.
   typedef struct packed {
      logic [5:0]  rob_tag;
      logic [3:0]  alu_op;
      logic [6:0]  prs1;
      logic [6:0]  prs2;
      logic [6:0]  prd;
      logic [31:0] imm;
   } dispatch_pipeline_data;
endpackage

module alu_dispatch_unit
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [1:0]            ren_valid,
   input  dispatch_pipeline_data ren_instr0,
   input  dispatch_pipeline_data ren_instr1,
   output logic                  ren_ready,
   input  logic                  rs_ready_in,
   input  logic                  rs_ready_in2,
   output logic                  valid_out_1,
   output logic                  valid_out_2,
   output dispatch_pipeline_data instr1,
   output dispatch_pipeline_data instr2,
   output logic [31:0]           stat_dispatched,
   output logic [31:0]           stat_stall
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("alu_dispatch_unit: DEPTH must be a power of two and at least 4");
   end

   dispatch_pipeline_data q [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W-1:0]      head_p1;
   logic [PTR_W-1:0]      tail_p1;
   logic [CNT_W-1:0]      count;
   logic                  fire1;
   logic                  fire2;
   logic [1:0]            deq;
   logic [1:0]            enq;

   // Handshake terms: valids, in-order fire, and enqueue acceptance.
   always_comb begin
      head_p1     = head + PTR_W'(1);
      tail_p1     = tail + PTR_W'(1);
      valid_out_1 = (count >= CNT_W'(1)) && !flush;
      valid_out_2 = (count >= CNT_W'(2)) && !flush;
      // Depends on current count only, so a full queue never overflows.
      ren_ready   = (count <= CNT_W'(DEPTH - 2));
      fire1       = valid_out_1 && rs_ready_in;
      fire2       = fire1 && valid_out_2 && rs_ready_in2;
      deq         = {1'b0, fire1} + {1'b0, fire2};
      enq         = 2'd0;
      if (ren_ready) begin
         case (ren_valid)
            2'b01:   enq = 2'd1;
            2'b11:   enq = 2'd2;
            default: enq = 2'd0;
         endcase
      end
   end

   assign instr1 = q[head];
   assign instr2 = q[head_p1];

   // Pointer and occupancy update; flush squashes same-cycle traffic.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq);
         tail  <= tail + PTR_W'(enq);
         count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // Storage write; contents are intentionally left alone on reset/flush.
   always_ff @(posedge clk) begin
      if (!reset && !flush && enq != 2'd0) begin
         q[tail] <= ren_instr0;
         if (enq == 2'd2) begin
            q[tail_p1] <= ren_instr1;
         end
      end
   end

`ifdef ALU_DISPATCH_STATS_EN
   logic [31:0] disp_cnt;
   logic [31:0] stall_cnt;

   // Free-running dispatch and stall counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         disp_cnt <= disp_cnt + 32'(deq);
         if (valid_out_1 && !rs_ready_in) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign stat_dispatched = disp_cnt;
   assign stat_stall      = stall_cnt;
`else
   assign stat_dispatched = '0;
   assign stat_stall      = '0;
`endif

   // Older slot must be valid whenever the younger one is.
   always @(posedge clk) begin
      if (!reset) begin
         assert (ren_valid != 2'b10);
      end
   end

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Self-checking bench for alu_dispatch_unit: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_alu_dispatch_unit;
   import alu_dispatch_pkg::*;

   localparam int unsigned DEPTH = 8;
`ifdef ALU_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  flush;
   logic [1:0]            ren_valid;
   dispatch_pipeline_data ren_instr0;
   dispatch_pipeline_data ren_instr1;
   logic                  ren_ready;
   logic                  rs_ready_in;
   logic                  rs_ready_in2;
   logic                  valid_out_1;
   logic                  valid_out_2;
   dispatch_pipeline_data instr1;
   dispatch_pipeline_data instr2;
   logic [31:0]           stat_dispatched;
   logic [31:0]           stat_stall;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: program-ordered queue of pending instructions.
   dispatch_pipeline_data mq[$];
   int unsigned           exp_disp  = 0;
   int unsigned           exp_stall = 0;

   alu_dispatch_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .ren_valid(ren_valid),
      .ren_instr0(ren_instr0), .ren_instr1(ren_instr1), .ren_ready(ren_ready),
      .rs_ready_in(rs_ready_in), .rs_ready_in2(rs_ready_in2),
      .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
      .instr1(instr1), .instr2(instr2),
      .stat_dispatched(stat_dispatched), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   function automatic dispatch_pipeline_data mk(input int tag);
      dispatch_pipeline_data d;
      d.rob_tag = 6'(tag);
      d.alu_op  = 4'($urandom);
      d.prs1    = 7'($urandom);
      d.prs2    = 7'($urandom);
      d.prd     = 7'($urandom);
      d.imm     = $urandom;
      return d;
   endfunction

   // Apply inputs (called just after a falling edge) and let them settle.
   task automatic drive(input logic [1:0] rv, input dispatch_pipeline_data a,
                        input dispatch_pipeline_data b, input logic r1,
                        input logic r2, input logic fl);
      ren_valid    = rv;
      ren_instr0   = a;
      ren_instr1   = b;
      rs_ready_in  = r1;
      rs_ready_in2 = r2;
      flush        = fl;
      #1;
   endtask

   // Advance one clock; the model applies the rules from the driven inputs.
   task automatic tick();
      int sz;
      bit v1, v2, f1, f2, acc;
      int n_enq;
      sz    = mq.size();
      v1    = (sz >= 1) && !flush;
      v2    = (sz >= 2) && !flush;
      f1    = v1 && rs_ready_in;
      f2    = f1 && v2 && rs_ready_in2;
      acc   = (int'(DEPTH) - sz) >= 2;
      n_enq = !acc ? 0 : (ren_valid == 2'b01) ? 1 : (ren_valid == 2'b11) ? 2 : 0;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         exp_disp  = 0;
         exp_stall = 0;
      end else begin
         if (v1 && !rs_ready_in) exp_stall++;
         if (flush) begin
            mq.delete();
         end else begin
            if (f1) begin void'(mq.pop_front()); exp_disp++; end
            if (f2) begin void'(mq.pop_front()); exp_disp++; end
            if (n_enq >= 1) mq.push_back(ren_instr0);
            if (n_enq == 2) mq.push_back(ren_instr1);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (ren_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ren_ready: got %b want 1", ren_ready); end
      n_cmp++; if (valid_out_1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b want 0", valid_out_1); end
      n_cmp++; if (valid_out_2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b want 0", valid_out_2); end
      n_cmp++; if (stat_dispatched !== 32'd0 || stat_stall !== 32'd0) begin
         n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_dispatched, stat_stall);
      end
   endtask

   task automatic test_pair_dispatch();
      dispatch_pipeline_data a, b;
      a = mk(1);
      b = mk(2);
      drive(2'b11, a, b, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (valid_out_1 !== 1'b0) begin n_fail++; $display("FAIL pair_empty_valid: got %b want 0", valid_out_1); end
      tick();
      drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (valid_out_1 !== 1'b1 || valid_out_2 !== 1'b1) begin
         n_fail++; $display("FAIL pair_valids: got %b%b want 11", valid_out_1, valid_out_2);
      end
      n_cmp++; if (instr1 !== a) begin n_fail++; $display("FAIL pair_instr1: got %h want %h", instr1, a); end
      n_cmp++; if (instr2 !== b) begin n_fail++; $display("FAIL pair_instr2: got %h want %h", instr2, b); end
      tick();
      n_cmp++; if (valid_out_1 !== 1'b0 || valid_out_2 !== 1'b0) begin
         n_fail++; $display("FAIL pair_drained: got %b%b want 00", valid_out_1, valid_out_2);
      end
   endtask

   task automatic test_single_ready();
      dispatch_pipeline_data c, d;
      c = mk(3);
      d = mk(4);
      drive(2'b11, c, d, 1'b0, 1'b0, 1'b0);
      tick();
      drive(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (instr1 !== c || valid_out_2 !== 1'b1) begin
         n_fail++; $display("FAIL single_head: got %h v2=%b want %h v2=1", instr1, valid_out_2, c);
      end
      tick();
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (instr1 !== d || valid_out_1 !== 1'b1) begin
         n_fail++; $display("FAIL single_next: got %h v1=%b want %h v1=1", instr1, valid_out_1, d);
      end
      n_cmp++; if (valid_out_2 !== 1'b0) begin n_fail++; $display("FAIL single_valid2: got %b want 0", valid_out_2); end
      drive(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_full();
      int obs = 0;
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, mk(10 + 2 * i), mk(11 + 2 * i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(2'b01, mk(16), '0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(2'b11, mk(17), mk(18), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ren_ready !== 1'b0) begin n_fail++; $display("FAIL full_ren_ready: got %b want 0", ren_ready); end
      tick();
      drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (ren_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got %b want 0", ren_ready); end
      for (int i = 0; i < 10; i++) begin
         drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
         if (valid_out_1 && mq.size() > 0) begin
            n_cmp++; if (instr1 !== mq[0]) begin n_fail++; $display("FAIL full_drain_order: got %h want %h", instr1, mq[0]); end
         end
         obs += int'(valid_out_1) + int'(valid_out_2);
         tick();
      end
      n_cmp++; if (obs != 7) begin n_fail++; $display("FAIL full_drain_count: got %0d want 7", obs); end
   endtask

   task automatic test_flush();
      dispatch_pipeline_data z;
      drive(2'b11, mk(20), mk(21), 1'b0, 1'b0, 1'b0); tick();
      drive(2'b11, mk(22), mk(23), 1'b0, 1'b0, 1'b0); tick();
      drive(2'b01, mk(24), '0, 1'b0, 1'b0, 1'b0); tick();
      drive(2'b11, mk(25), mk(26), 1'b1, 1'b1, 1'b1);
      n_cmp++; if (valid_out_1 !== 1'b0 || valid_out_2 !== 1'b0) begin
         n_fail++; $display("FAIL flush_same_cycle: got %b%b want 00", valid_out_1, valid_out_2);
      end
      tick();
      drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (valid_out_1 !== 1'b0 || valid_out_2 !== 1'b0 || ren_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_after: got v=%b%b rdy=%b want v=00 rdy=1", valid_out_1, valid_out_2, ren_ready);
      end
      z = mk(27);
      drive(2'b01, z, '0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (valid_out_1 !== 1'b1 || instr1 !== z) begin
         n_fail++; $display("FAIL flush_refill: got v1=%b %h want v1=1 %h", valid_out_1, instr1, z);
      end
      tick();
   endtask

   task automatic test_stream_wrap();
      dispatch_pipeline_data src[12];
      dispatch_pipeline_data got[$];
      dispatch_pipeline_data a, b;
      logic [1:0] rv;
      logic r1, r2;
      int nxt = 0;
      int cyc = 0;
      int sel;
      for (int i = 0; i < 12; i++) src[i] = mk(i);
      while ((nxt < 12 || got.size() < 12) && cyc < 300) begin
         sel = int'($urandom_range(0, 3));
         rv  = 2'b00;
         a   = '0;
         b   = '0;
         if (nxt < 12) begin
            a  = src[nxt];
            rv = (sel == 0) ? 2'b00 : (sel == 1 || nxt == 11) ? 2'b01 : 2'b11;
            if (nxt < 11) b = src[nxt + 1];
         end
         r1 = 1'($urandom_range(0, 1));
         r2 = 1'($urandom_range(0, 1));
         drive(rv, a, b, r1, r2, 1'b0);
         n_cmp++; if (ren_ready !== ((int'(DEPTH) - mq.size()) >= 2)) begin
            n_fail++; $display("FAIL stream_ren_ready: got %b with %0d queued", ren_ready, mq.size());
         end
         if (valid_out_1 && r1) got.push_back(instr1);
         if (valid_out_1 && r1 && valid_out_2 && r2) got.push_back(instr2);
         if (ren_ready) nxt += (rv == 2'b11) ? 2 : (rv == 2'b01) ? 1 : 0;
         tick();
         cyc++;
      end
      n_cmp++; if (got.size() != 12) begin n_fail++; $display("FAIL stream_count: got %0d want 12", got.size()); end
      for (int i = 0; i < 12 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== src[i]) begin
            n_fail++; $display("FAIL stream_order[%0d]: got tag %0d want tag %0d", i, got[i].rob_tag, src[i].rob_tag);
         end
      end
   endtask

   task automatic test_stats();
      reset = 1'b1;
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, mk(30 + 2 * i), mk(31 + 2 * i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
         tick();
      end
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (stat_dispatched !== (STATS ? 32'd6 : 32'd0)) begin
         n_fail++; $display("FAIL stats_dispatched: got %0d want %0d", stat_dispatched, STATS ? 6 : 0);
      end
      n_cmp++; if (stat_stall !== (STATS ? 32'd3 : 32'd0)) begin
         n_fail++; $display("FAIL stats_stall: got %0d want %0d", stat_stall, STATS ? 3 : 0);
      end
   endtask

   task automatic test_random();
      int sel;
      logic [1:0] rv;
      logic fl;
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 2));
         rv  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
         fl  = ($urandom_range(0, 15) == 0);
         drive(rv, mk(40 + i), mk(41 + i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fl);
         n_cmp++; if (valid_out_1 !== (mq.size() >= 1 && !fl) || valid_out_2 !== (mq.size() >= 2 && !fl)) begin
            n_fail++; $display("FAIL rand_valids[%0d]: got %b%b with %0d queued", i, valid_out_1, valid_out_2, mq.size());
         end
         n_cmp++; if (ren_ready !== ((int'(DEPTH) - mq.size()) >= 2)) begin
            n_fail++; $display("FAIL rand_ren_ready[%0d]: got %b with %0d queued", i, ren_ready, mq.size());
         end
         if (mq.size() >= 1) begin
            n_cmp++; if (instr1 !== mq[0]) begin n_fail++; $display("FAIL rand_instr1[%0d]: got %h want %h", i, instr1, mq[0]); end
         end
         if (mq.size() >= 2) begin
            n_cmp++; if (instr2 !== mq[1]) begin n_fail++; $display("FAIL rand_instr2[%0d]: got %h want %h", i, instr2, mq[1]); end
         end
         tick();
      end
      drive(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (stat_dispatched !== (STATS ? exp_disp : 32'd0)) begin
         n_fail++; $display("FAIL rand_stat_dispatched: got %0d want %0d", stat_dispatched, STATS ? exp_disp : 0);
      end
      n_cmp++; if (stat_stall !== (STATS ? exp_stall : 32'd0)) begin
         n_fail++; $display("FAIL rand_stat_stall: got %0d want %0d", stat_stall, STATS ? exp_stall : 0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      flush        = 1'b0;
      ren_valid    = 2'b00;
      ren_instr0   = '0;
      ren_instr1   = '0;
      rs_ready_in  = 1'b0;
      rs_ready_in2 = 1'b0;
      @(negedge clk);
      test_reset();
      test_pair_dispatch();
      test_single_ready();
      test_full();
      test_flush();
      test_stream_wrap();
      test_stats();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
